// File: rtl/multi_osc_wavegen_if.sv
// Host and modulator signals of the oscillator bank.
// The master side (host / modulator) drives the byte-pair write bus and
// the sample request; the slave side (the oscillator bank) returns the
// mixed sample and its status strobes.
interface multi_osc_wavegen_if #(
    parameter int ADDR_BITS = 4,
    parameter int OUT_BITS  = 18
);
    logic [7:0]           data_in;
    logic [ADDR_BITS-1:0] addr;
    logic                 data_part_in;
    logic                 sample_req;
    logic [OUT_BITS-1:0]  sample_out;
    logic                 sample_valid;
    logic                 busy;
    logic                 overrun;

    modport master (
        output data_in,
        output addr,
        output data_part_in,
        output sample_req,
        input  sample_out,
        input  sample_valid,
        input  busy,
        input  overrun
    );

    modport slave (
        input  data_in,
        input  addr,
        input  data_part_in,
        input  sample_req,
        output sample_out,
        output sample_valid,
        output busy,
        output overrun
    );
endinterface

// File: rtl/multi_osc_wavegen.sv
// Time-multiplexed oscillator bank feeding the delta-sigma PWM modulator.
// A byte-pair host bus loads per-channel PHASE / DELTA / CTRL words. Each
// modulator sample request steps every enabled channel once (one channel
// per clock), scales it by its volume shift and sums the channels into an
// unsigned sample that is wide enough never to overflow.
module multi_osc_wavegen #(
    parameter int NUM_CH    = 4,
    parameter int ACC_BITS  = 16,
    parameter int ADDR_BITS = 4,
    parameter int OUT_BITS  = 18
) (
    input logic                clk,
    input logic                reset,
    multi_osc_wavegen_if.slave bus
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    localparam logic [1:0] MODE_SAW    = 2'd0;
    localparam logic [1:0] MODE_TRI    = 2'd1;
    localparam logic [1:0] MODE_SQUARE = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_STEP, S_DONE} state_t;

    // Square waves only look at the phase MSB; every other mode outputs
    // the phase directly.
    function automatic logic [ACC_BITS-1:0] wave_value(
        input logic [ACC_BITS-1:0] ph,
        input logic [1:0]          mode
    );
        if (mode == MODE_SQUARE)
            return {ACC_BITS{ph[ACC_BITS-1]}};
        return ph;
    endfunction

    // Register file and per-channel triangle direction (0 = up).
    logic [ACC_BITS-1:0] phase_r [NUM_CH];
    logic [ACC_BITS-1:0] delta_r [NUM_CH];
    logic [5:0]          ctrl_r  [NUM_CH];
    logic                dir_r   [NUM_CH];

    // Host strobe synchroniser: bit 2 is the newest sample.
    logic [2:0]           sreg;
    logic [7:0]           data_low;
    logic                 data_part;
    logic                 data_last;
    logic                 host_we;
    logic                 data_fall;
    logic [ADDR_BITS-1:0] wr_ch;
    logic [1:0]           wr_sel;
    logic [ACC_BITS-1:0]  wr_data;

    assign data_part = sreg[1];
    assign data_last = sreg[0];
    assign host_we   = data_part & ~data_last;
    assign data_fall = ~data_part & data_last;
    assign wr_ch     = bus.addr >> 2;
    assign wr_sel    = bus.addr[1:0];
    assign wr_data   = {bus.data_in, data_low};

    // Sequencer state.
    state_t              state;
    logic [CH_W-1:0]     ch_idx;
    logic [OUT_BITS-1:0] acc;
    logic                pending;
    logic                step_en;

    assign step_en = (state == S_STEP);

    // Step datapath for the channel selected by ch_idx.
    logic [ACC_BITS-1:0] cur_phase;
    logic [ACC_BITS-1:0] cur_delta;
    logic [5:0]          cur_ctrl;
    logic                cur_dir;
    logic [ACC_BITS:0]   sum_up;
    logic [ACC_BITS:0]   sum_dn;
    logic [ACC_BITS-1:0] nxt_phase;
    logic                nxt_dir;
    logic [ACC_BITS-1:0] wave_sh;
    logic [OUT_BITS-1:0] contrib;

    // Compute the next phase/direction and the scaled contribution.
    always_comb begin
        cur_phase = phase_r[ch_idx];
        cur_delta = delta_r[ch_idx];
        cur_ctrl  = ctrl_r[ch_idx];
        cur_dir   = dir_r[ch_idx];
        sum_up    = {1'b0, cur_phase} + {1'b0, cur_delta};
        sum_dn    = {1'b0, cur_phase} - {1'b0, cur_delta};
        nxt_phase = cur_phase;
        nxt_dir   = cur_dir;
        wave_sh   = '0;
        contrib   = '0;
        if (cur_ctrl[0]) begin
            case (cur_ctrl[2:1])
                MODE_SAW, MODE_SQUARE: nxt_phase = sum_up[ACC_BITS-1:0];
                MODE_TRI: begin
                    // The triangle turns around before entering the top
                    // or bottom quarter, holding the phase on the turn.
                    if (!cur_dir) begin
                        if (sum_up[ACC_BITS] || (sum_up[ACC_BITS-1 -: 2] == 2'b11))
                            nxt_dir = 1'b1;
                        else
                            nxt_phase = sum_up[ACC_BITS-1:0];
                    end else begin
                        if (sum_dn[ACC_BITS] || (sum_dn[ACC_BITS-1 -: 2] == 2'b00))
                            nxt_dir = 1'b0;
                        else
                            nxt_phase = sum_dn[ACC_BITS-1:0];
                    end
                end
                default: ;
            endcase
            wave_sh = wave_value(nxt_phase, cur_ctrl[2:1]) >> cur_ctrl[5:3];
            contrib = OUT_BITS'(wave_sh);
        end
    end

    // Host byte-pair capture, register writes and channel phase updates.
    // Host writes are applied after the step update so they take priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg     <= 3'b111;
            data_low <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                phase_r[c] <= '0;
                delta_r[c] <= '0;
                ctrl_r[c]  <= '0;
                dir_r[c]   <= 1'b0;
            end
        end else begin
            sreg <= {bus.data_part_in, sreg[2:1]};
            if (data_fall)
                data_low <= bus.data_in;
            if (step_en) begin
                phase_r[ch_idx] <= nxt_phase;
                dir_r[ch_idx]   <= nxt_dir;
            end
            if (host_we) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (int'(wr_ch) == c) begin
                        case (wr_sel)
                            2'd0: phase_r[c] <= wr_data;
                            2'd1: delta_r[c] <= wr_data;
                            2'd2: begin
                                ctrl_r[c] <= wr_data[5:0];
                                dir_r[c]  <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // Sequencer: IDLE -> STEP x NUM_CH -> DONE, with one queued request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            ch_idx           <= '0;
            acc              <= '0;
            pending          <= 1'b0;
            bus.sample_out   <= '0;
            bus.sample_valid <= 1'b0;
            bus.busy         <= 1'b0;
            bus.overrun      <= 1'b0;
        end else begin
            bus.sample_valid <= 1'b0;
            bus.overrun      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.sample_req || pending) begin
                        state    <= S_STEP;
                        ch_idx   <= '0;
                        bus.busy <= 1'b1;
                        // A fresh request arriving while a queued one is
                        // being started stays queued.
                        pending  <= pending & bus.sample_req;
                    end
                end
                S_STEP: begin
                    acc <= ((ch_idx == '0) ? '0 : acc) + contrib;
                    if (ch_idx == LAST_CH)
                        state <= S_DONE;
                    else
                        ch_idx <= ch_idx + CH_W'(1);
                end
                S_DONE: begin
                    bus.sample_out   <= acc;
                    bus.sample_valid <= 1'b1;
                    bus.busy         <= 1'b0;
                    state            <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if ((state != S_IDLE) && bus.sample_req) begin
                if (pending)
                    bus.overrun <= 1'b1;
                else
                    pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multi_osc_wavegen.sv
// Bench for the oscillator bank: directed scenarios plus random register
// loads, compared against a plain-arithmetic channel model.
module tb_multi_osc_wavegen;

    localparam int NUM_CH    = 4;
    localparam int ACC_BITS  = 16;
    localparam int ADDR_BITS = 4;
    localparam int OUT_BITS  = 18;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    multi_osc_wavegen_if #(.ADDR_BITS(ADDR_BITS), .OUT_BITS(OUT_BITS)) bus ();

    multi_osc_wavegen #(
        .NUM_CH   (NUM_CH),
        .ACC_BITS (ACC_BITS),
        .ADDR_BITS(ADDR_BITS),
        .OUT_BITS (OUT_BITS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: what the register file and oscillators should hold.
    int m_phase [NUM_CH];
    int m_delta [NUM_CH];
    int m_ctrl  [NUM_CH];
    bit m_dir   [NUM_CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_phase[c] = 0;
            m_delta[c] = 0;
            m_ctrl[c]  = 0;
            m_dir[c]   = 1'b0;
        end
    endtask

    // One sample: advance every enabled channel, then sum the scaled waves.
    task automatic model_sample(output int res);
        int s;
        int wave;
        int mode;
        int vol;
        res = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            if ((m_ctrl[c] & 1) != 0) begin
                mode = (m_ctrl[c] >> 1) & 3;
                vol  = (m_ctrl[c] >> 3) & 7;
                case (mode)
                    0, 2: m_phase[c] = (m_phase[c] + m_delta[c]) % 65536;
                    1: begin
                        if (!m_dir[c]) begin
                            s = m_phase[c] + m_delta[c];
                            if (s >= 'hC000) m_dir[c] = 1'b1;
                            else m_phase[c] = s;
                        end else begin
                            s = m_phase[c] - m_delta[c];
                            if (s < 'h4000) m_dir[c] = 1'b0;
                            else m_phase[c] = s;
                        end
                    end
                    default: ;
                endcase
                if (mode == 2) wave = (m_phase[c] >= 'h8000) ? 'hFFFF : 0;
                else wave = m_phase[c];
                res += wave >> vol;
            end
        end
    endtask

    // Byte-pair host write: low byte on the falling strobe, high byte and
    // commit on the rising strobe.
    task automatic host_write(input logic [ADDR_BITS-1:0] a, input logic [15:0] d);
        int ch;
        @(negedge clk);
        bus.addr         = a;
        bus.data_in      = d[7:0];
        bus.data_part_in = 1'b0;
        repeat (4) @(negedge clk);
        bus.data_in = d[15:8];
        repeat (4) @(negedge clk);
        bus.data_part_in = 1'b1;
        repeat (5) @(negedge clk);
        ch = int'(a) >> 2;
        if (ch < NUM_CH) begin
            case (int'(a) & 3)
                0: m_phase[ch] = int'(d);
                1: m_delta[ch] = int'(d);
                2: begin
                    m_ctrl[ch] = int'(d) & 'h3F;
                    m_dir[ch]  = 1'b0;
                end
                default: ;
            endcase
        end
    endtask

    // Issue one request, check busy, latency, value and pulse width.
    task automatic request_and_check(input string tag, output logic [OUT_BITS-1:0] obs);
        int exp;
        int lat;
        model_sample(exp);
        lat = 0;
        obs = '0;
        @(negedge clk);
        bus.sample_req = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus.sample_req = 1'b0;
            if (i == 1) check({tag, " busy"}, 32'(bus.busy), 32'd1);
            if (bus.sample_valid) begin
                lat = i;
                obs = bus.sample_out;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(NUM_CH + 2));
        check({tag, " sample"}, 32'(obs), 32'(exp));
        @(negedge clk);
        check({tag, " valid_pulse"}, 32'(bus.sample_valid), 32'd0);
    endtask

    function automatic logic [15:0] mk_ctrl(input int en, input int mode, input int vol);
        return 16'((en & 1) | ((mode & 3) << 1) | ((vol & 7) << 3));
    endfunction

    int tri_exp [10] = '{'hB000, 'hA000, 'h9000, 'h8000, 'h7000, 'h6000,
                         'h5000, 'h4000, 'h4000, 'h5000};

    initial begin
        logic [OUT_BITS-1:0] obs;
        int e1;
        int e2;
        int nv;
        int nov;
        int t1;
        int t2;
        int tov;
        logic [OUT_BITS-1:0] o1;
        logic [OUT_BITS-1:0] o2;

        // Reset with the strobe high: nothing must be written.
        reset            = 1'b1;
        bus.data_part_in = 1'b1;
        bus.data_in      = 8'h00;
        bus.addr         = '0;
        bus.sample_req   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst sample_out", 32'(bus.sample_out), 32'd0);
        check("rst valid", 32'(bus.sample_valid), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst overrun", 32'(bus.overrun), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        request_and_check("idle_zero", obs);

        // DELTA load via byte pair, then a write to the unused slot.
        host_write(4'd1, 16'h1234);
        host_write(4'd2, mk_ctrl(1, 0, 0));
        request_and_check("delta1234", obs);
        check("delta1234 const", 32'(obs), 32'h1234);
        host_write(4'd3, 16'hFFFF);
        request_and_check("sel3_ignored", obs);
        check("sel3_ignored const", 32'(obs), 32'h2468);

        // Saw: 16 samples stepping by 0x1000, wrapping to zero.
        host_write(4'd0, 16'h0000);
        host_write(4'd1, 16'h1000);
        for (int i = 1; i <= 16; i++) begin
            request_and_check("saw", obs);
            check("saw const", 32'(obs), 32'((i * 'h1000) % 'h10000));
        end

        // Triangle: turn at the top, walk down, hold at the floor, turn up.
        host_write(4'd0, 16'hB000);
        host_write(4'd2, mk_ctrl(1, 1, 0));
        for (int i = 0; i < 10; i++) begin
            request_and_check("tri", obs);
            check("tri const", 32'(obs), 32'(tri_exp[i]));
        end

        // Four-channel mix with volume shift, square and a disabled channel.
        host_write(4'd0, 16'hFFFF);
        host_write(4'd2, mk_ctrl(1, 3, 0));
        host_write(4'd4, 16'hFFFF);
        host_write(4'd6, mk_ctrl(1, 3, 1));
        host_write(4'd8, 16'h8000);
        host_write(4'd9, 16'h0000);
        host_write(4'd10, mk_ctrl(1, 2, 0));
        host_write(4'd12, 16'h1111);
        host_write(4'd14, mk_ctrl(0, 0, 0));
        request_and_check("mix", obs);
        check("mix const", 32'(obs), 32'h27FFD);

        // Random register loads followed by a few samples each.
        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 5; w++)
                host_write(ADDR_BITS'($urandom_range(0, 15)), 16'($urandom));
            for (int q = 0; q < 3; q++)
                request_and_check("random", obs);
        end

        // Back-to-back requests: one queued, one dropped.
        model_sample(e1);
        model_sample(e2);
        nv  = 0;
        nov = 0;
        t1  = 0;
        t2  = 0;
        tov = 0;
        o1  = '0;
        o2  = '0;
        @(negedge clk);
        bus.sample_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus.sample_req = (c == 2) || (c == 3);
            if (bus.sample_valid) begin
                if (nv == 0) begin
                    t1 = c;
                    o1 = bus.sample_out;
                end else if (nv == 1) begin
                    t2 = c;
                    o2 = bus.sample_out;
                end
                nv++;
            end
            if (bus.overrun) begin
                nov++;
                tov = c;
            end
        end
        bus.sample_req = 1'b0;
        check("ovr valid_count", 32'(nv), 32'd2);
        check("ovr first_time", 32'(t1), 32'(NUM_CH + 2));
        check("ovr spacing", 32'(t2 - t1), 32'(NUM_CH + 2));
        check("ovr first_sample", 32'(o1), 32'(e1));
        check("ovr second_sample", 32'(o2), 32'(e2));
        check("ovr pulse_count", 32'(nov), 32'd1);
        check("ovr pulse_time", 32'(tov), 32'd4);

        // Reset in the middle of stepping with a request queued.
        @(negedge clk);
        bus.sample_req = 1'b1;
        @(negedge clk);
        bus.sample_req = 1'b0;
        @(negedge clk);
        bus.sample_req = 1'b1;
        @(negedge clk);
        bus.sample_req = 1'b0;
        check("midrst busy_before", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst sample_out", 32'(bus.sample_out), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        nv = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.sample_valid) nv++;
        end
        check("midrst no_pending", 32'(nv), 32'd0);
        request_and_check("post_reset", obs);
        check("post_reset const", 32'(obs), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
